// File: rtl/skeleton_pkg.sv
// Shared encodings for the skeleton_ta processor: opcodes, R-type ALU
// selectors, the r30 exception codes and the immediate sign-extension helper.
package skeleton_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    // Values written to r30 when a signed overflow replaces the normal result.
    localparam logic [31:0] EXC_ADD  = 32'd1;
    localparam logic [31:0] EXC_ADDI = 32'd2;
    localparam logic [31:0] EXC_SUB  = 32'd3;

    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK   = 5'd31;

    function automatic logic [31:0] sign_ext17(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

endpackage

// File: rtl/skeleton_ta_if.sv
// Register-file port bundle: one write port and two combinational read ports.
// There is no handshake: a write is committed on the rising clock edge
// whenever write_enable is high, and read data follows the read indices
// combinationally within the same cycle.
interface skeleton_ta_if;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg_a;
    logic [4:0]  read_reg_b;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;

    modport master (
        output write_enable, write_reg, write_data, read_reg_a, read_reg_b,
        input  read_data_a, read_data_b
    );

    modport slave (
        input  write_enable, write_reg, write_data, read_reg_a, read_reg_b,
        output read_data_a, read_data_b
    );
endinterface

// File: rtl/skeleton_regfile.sv
// 32x32 register file, two combinational reads, one synchronous write,
// asynchronous active-low clear. r0 is never written so it always reads 0.
module skeleton_regfile (
    input  logic         clock,
    input  logic         reset,
    skeleton_ta_if.slave rf
);
    logic [31:0] register_output [0:31];

    // Clear everything on reset; otherwise commit the write port, skipping r0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                register_output[i] <= '0;
            end
        end else if (rf.write_enable && (rf.write_reg != 5'd0)) begin
            register_output[rf.write_reg] <= rf.write_data;
        end
    end

    assign rf.read_data_a = register_output[rf.read_reg_a];
    assign rf.read_data_b = register_output[rf.read_reg_b];

endmodule

// File: rtl/skeleton_ta.sv
// Single-cycle 32-bit processor top: PC, decode/control, ALU, register file,
// instruction ROM and data RAM. One instruction retires per rising edge and
// every memory/regfile net is exported for observation.
module skeleton_ta
    import skeleton_pkg::*;
#(
    parameter string IMEM_INIT  = "imem.mem",
    parameter int    DMEM_DEPTH = 4096
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] address_imem,
    output logic [31:0] q_imem,
    output logic [11:0] address_dmem,
    output logic [31:0] d_dmem,
    output logic        wren_dmem,
    output logic [31:0] q_dmem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB
);
    logic [31:0] imem [0:4095];
    logic [31:0] dmem [0:DMEM_DEPTH-1];

    // RAM starts out all zero.
    initial begin
        for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
    end

    skeleton_ta_if rf ();
    skeleton_regfile u_regfile (.clock(clock), .reset(reset), .rf(rf));

    logic [31:0] pc, pc_next, pc_plus1, branch_target;
    logic [31:0] instr, imm_ext, target, opa, opb;
    logic [31:0] sum_ab, diff_ab, sum_imm, alu_result, wr_data;
    logic [4:0]  opcode, rd, rs, rt, shamt, aluop, wr_reg;
    logic        ovf_add, ovf_sub, ovf_addi, wr_en, mem_we;

    assign instr   = imem[pc[11:0]];
    assign opcode  = instr[31:27];
    assign rd      = instr[26:22];
    assign rs      = instr[21:17];
    assign rt      = instr[16:12];
    assign shamt   = instr[11:7];
    assign aluop   = instr[6:2];
    assign imm_ext = sign_ext17(instr[16:0]);
    assign target  = {5'b0, instr[26:0]};

    // Port A normally reads $rs (r30 for bex); port B reads $rt for R-type, else $rd.
    always_comb begin
        rf.read_reg_a = rs;
        rf.read_reg_b = rd;
        if (opcode == OP_BEX)   rf.read_reg_a = REG_STATUS;
        if (opcode == OP_RTYPE) rf.read_reg_b = rt;
    end

    assign opa = rf.read_data_a;
    assign opb = rf.read_data_b;

    assign sum_ab   = opa + opb;
    assign diff_ab  = opa - opb;
    assign sum_imm  = opa + imm_ext;
    assign ovf_add  = (opa[31] == opb[31]) && (sum_ab[31] != opa[31]);
    assign ovf_sub  = (opa[31] != opb[31]) && (diff_ab[31] != opa[31]);
    assign ovf_addi = (opa[31] == imm_ext[31]) && (sum_imm[31] != opa[31]);

    assign pc_plus1      = pc + 32'd1;
    assign branch_target = pc_plus1 + imm_ext;

    // ALU: R-type operation, otherwise the $rs + imm address/sum.
    always_comb begin
        alu_result = sum_imm;
        if (opcode == OP_RTYPE) begin
            case (aluop)
                ALU_ADD: alu_result = sum_ab;
                ALU_SUB: alu_result = diff_ab;
                ALU_AND: alu_result = opa & opb;
                ALU_OR:  alu_result = opa | opb;
                ALU_SLL: alu_result = opa << shamt;
                ALU_SRA: alu_result = $signed(opa) >>> shamt;
                default: alu_result = sum_imm;
            endcase
        end
    end

    // Control: next PC and regfile/RAM write requests for the current instruction.
    always_comb begin
        pc_next = pc_plus1;
        wr_en   = 1'b0;
        wr_reg  = rd;
        wr_data = alu_result;
        mem_we  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (aluop <= ALU_SRA) wr_en = 1'b1;
                if (aluop == ALU_ADD && ovf_add) begin
                    wr_reg  = REG_STATUS;
                    wr_data = EXC_ADD;
                end
                if (aluop == ALU_SUB && ovf_sub) begin
                    wr_reg  = REG_STATUS;
                    wr_data = EXC_SUB;
                end
            end
            OP_J:    pc_next = target;
            OP_BNE:  if (opb != opa) pc_next = branch_target;
            OP_JAL: begin
                wr_en   = 1'b1;
                wr_reg  = REG_LINK;
                wr_data = pc_plus1;
                pc_next = target;
            end
            OP_JR:   pc_next = opb;
            OP_ADDI: begin
                wr_en = 1'b1;
                if (ovf_addi) begin
                    wr_reg  = REG_STATUS;
                    wr_data = EXC_ADDI;
                end
            end
            OP_BLT:  if ($signed(opb) < $signed(opa)) pc_next = branch_target;
            OP_SW:   mem_we = 1'b1;
            OP_LW: begin
                wr_en   = 1'b1;
                wr_data = q_dmem;
            end
            OP_SETX: begin
                wr_en   = 1'b1;
                wr_reg  = REG_STATUS;
                wr_data = target;
            end
            OP_BEX:  if (opa != 32'd0) pc_next = target;
            default: pc_next = pc_plus1;
        endcase
    end

    // PC register: cleared asynchronously, otherwise advances every edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc <= '0;
        else        pc <= pc_next;
    end

    // Data RAM write port.
    always_ff @(posedge clock) begin
        if (wren_dmem) dmem[address_dmem] <= d_dmem;
    end

    // No write request may escape while reset is held.
    assign rf.write_enable = wr_en & reset;
    assign rf.write_reg    = wr_reg;
    assign rf.write_data   = wr_data;

    assign address_imem     = pc[11:0];
    assign q_imem           = instr;
    assign address_dmem     = alu_result[11:0];
    assign d_dmem           = opb;
    assign wren_dmem        = mem_we & reset;
    assign q_dmem           = dmem[address_dmem];
    assign ctrl_writeEnable = rf.write_enable;
    assign ctrl_writeReg    = rf.write_reg;
    assign ctrl_readRegA    = rf.read_reg_a;
    assign ctrl_readRegB    = rf.read_reg_b;
    assign data_writeReg    = rf.write_data;
    assign data_readRegA    = rf.read_data_a;
    assign data_readRegB    = rf.read_data_b;

endmodule

// File: tb/tb_skeleton_ta.sv
// Bench for skeleton_ta: loads a directed program into the ROM, queues the
// hand-computed register/RAM write events in program order, and a monitor
// pops and compares each write the processor presents.
module tb_skeleton_ta;
    import skeleton_pkg::*;

    localparam int W = 45;   // {is_mem, index[11:0], data[31:0]}

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] address_imem, address_dmem;
    logic [31:0] q_imem, d_dmem, q_dmem, data_writeReg, data_readRegA, data_readRegB;
    logic        wren_dmem, ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;

    int checks = 0;
    int failures = 0;
    logic monitor_on = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [31:0] prog [0:25];

    skeleton_ta #(.IMEM_INIT(""), .DMEM_DEPTH(4096)) dut (
        .clock(clock), .reset(reset),
        .address_imem(address_imem), .q_imem(q_imem),
        .address_dmem(address_dmem), .d_dmem(d_dmem), .wren_dmem(wren_dmem), .q_dmem(q_dmem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB)
    );

    skeleton_ta_if obs ();
    assign obs.write_enable = ctrl_writeEnable;
    assign obs.write_reg    = ctrl_writeReg;
    assign obs.write_data   = data_writeReg;
    assign obs.read_reg_a   = ctrl_readRegA;
    assign obs.read_reg_b   = ctrl_readRegB;
    assign obs.read_data_a  = data_readRegA;
    assign obs.read_data_b  = data_readRegB;

    always #5 clock = ~clock;

    function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt,
                                          logic [4:0] sh, logic [4:0] op);
        return {OP_RTYPE, rd, rs, rt, sh, op, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(logic [4:0] op, logic [4:0] rd, logic [4:0] rs, int imm);
        logic [31:0] v = imm;
        return {op, rd, rs, v[16:0]};
    endfunction

    function automatic logic [31:0] enc_j(logic [4:0] op, int t);
        logic [31:0] v = t;
        return {op, v[26:0]};
    endfunction

    task automatic load_program();
        prog[0]  = enc_i(OP_ADDI, 1, 0, 4);
        prog[1]  = enc_i(OP_ADDI, 2, 0, 150);
        prog[2]  = enc_i(OP_ADDI, 6, 0, 160);
        prog[3]  = enc_r(3, 0, 6, 0, ALU_SUB);
        prog[4]  = enc_i(OP_SW, 2, 1, 0);
        prog[5]  = enc_i(OP_LW, 5, 1, 0);
        prog[6]  = enc_i(OP_BNE, 1, 0, 1);
        prog[7]  = enc_i(OP_ADDI, 4, 0, 7);
        prog[8]  = enc_j(OP_JAL, 10);
        prog[9]  = enc_i(OP_ADDI, 7, 0, 3);
        prog[10] = enc_i(OP_ADDI, 8, 0, 5);
        prog[11] = enc_i(OP_BLT, 0, 1, 1);
        prog[12] = enc_i(OP_ADDI, 10, 0, 1);
        prog[13] = enc_i(OP_ADDI, 9, 0, 1);
        prog[14] = enc_i(OP_ADDI, 11, 0, 65535);
        prog[15] = enc_r(11, 11, 0, 15, ALU_SLL);
        prog[16] = enc_i(OP_ADDI, 11, 11, 32767);
        prog[17] = enc_r(12, 11, 11, 0, ALU_ADD);
        prog[18] = enc_i(OP_ADDI, 0, 0, 9);
        prog[19] = enc_j(OP_BEX, 21);
        prog[20] = enc_i(OP_ADDI, 14, 0, 1);
        prog[21] = enc_j(OP_SETX, 0);
        prog[22] = enc_r(15, 2, 1, 0, ALU_AND);
        prog[23] = enc_r(16, 2, 1, 0, ALU_OR);
        prog[24] = enc_r(17, 3, 0, 4, ALU_SRA);
        prog[25] = enc_j(OP_J, 25);
        for (int i = 0; i < 26; i++) dut.imem[i] = prog[i];
    endtask

    task automatic push_reg(logic [4:0] idx, logic [31:0] data);
        exp_q.push_back({1'b0, 7'd0, idx, data});
    endtask

    // Expected writes of one full pass, in retirement order.
    task automatic push_program_events();
        exp_q.delete();
        push_reg(1, 32'd4);
        push_reg(2, 32'd150);
        push_reg(6, 32'd160);
        push_reg(3, 32'hFFFF_FF60);
        exp_q.push_back({1'b1, 12'd4, 32'd150});
        push_reg(5, 32'd150);
        push_reg(31, 32'd9);
        push_reg(8, 32'd5);
        push_reg(9, 32'd1);
        push_reg(11, 32'h0000_FFFF);
        push_reg(11, 32'h7FFF_8000);
        push_reg(11, 32'h7FFF_FFFF);
        push_reg(30, 32'd1);
        push_reg(30, 32'd0);
        push_reg(15, 32'd4);
        push_reg(16, 32'd150);
        push_reg(17, 32'hFFFF_FFF6);
    endtask

    task automatic check_event(logic [W-1:0] got, string name);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected got=%h exp=<none>", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", name, got, exp);
            end
        end
    endtask

    task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_drain(int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
        repeat (12) @(negedge clock);
        check_val("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clock);
        #2 reset = 1'b1;
    endtask

    task automatic assert_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
    endtask

    // Monitor: every regfile write (r0 excluded) and RAM write is compared.
    always @(negedge clock) begin
        if (monitor_on && reset) begin
            if (obs.write_enable && obs.write_reg != 5'd0)
                check_event({1'b0, 7'd0, obs.write_reg, obs.write_data}, "regwrite");
            if (wren_dmem)
                check_event({1'b1, address_dmem, d_dmem}, "memwrite");
        end
    end

    initial begin
        load_program();
        #1 reset = 1'b0;
        #1;
        check_val("rst_pc", {20'd0, address_imem}, 32'd0);
        check_val("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
        check_val("rst_wren", {31'd0, wren_dmem}, 32'd0);
        check_val("rst_instr", q_imem, prog[0]);

        push_program_events();
        monitor_on = 1'b1;
        release_reset();
        wait_drain(200);

        check_val("r0", dut.u_regfile.register_output[0], 32'd0);
        check_val("r4_skipped", dut.u_regfile.register_output[4], 32'd0);
        check_val("r7_skipped", dut.u_regfile.register_output[7], 32'd0);
        check_val("r10_skipped", dut.u_regfile.register_output[10], 32'd0);
        check_val("r12_ovf", dut.u_regfile.register_output[12], 32'd0);
        check_val("r14_bex", dut.u_regfile.register_output[14], 32'd0);
        check_val("r5_lw", dut.u_regfile.register_output[5], 32'd150);
        check_val("r31_link", dut.u_regfile.register_output[31], 32'd9);
        check_val("ram4", dut.dmem[4], 32'd150);
        check_val("loop_pc", {20'd0, address_imem}, 32'd25);

        // Reset while spinning in the final loop.
        assert_reset();
        check_val("mid_pc", {20'd0, address_imem}, 32'd0);
        check_val("mid_we", {31'd0, ctrl_writeEnable}, 32'd0);
        for (int i = 0; i < 32; i++)
            check_val($sformatf("mid_r%0d", i), dut.u_regfile.register_output[i], 32'd0);

        // Restart, then reset again partway through the program.
        push_program_events();
        release_reset();
        repeat (6) @(negedge clock);
        assert_reset();
        check_val("mid2_pc", {20'd0, address_imem}, 32'd0);
        check_val("mid2_r1", dut.u_regfile.register_output[1], 32'd0);
        check_val("mid2_r3", dut.u_regfile.register_output[3], 32'd0);
        check_val("mid2_wren", {31'd0, wren_dmem}, 32'd0);

        push_program_events();
        release_reset();
        wait_drain(200);
        check_val("rerun_r31", dut.u_regfile.register_output[31], 32'd9);
        check_val("rerun_r17", dut.u_regfile.register_output[17], 32'hFFFF_FFF6);

        monitor_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
